// File: rtl/guitar_note_highway_pkg.sv
// rtl/guitar_note_highway_pkg.sv - shared FSM encoding and widths for the note highway
// Purpose: state encoding plus lane / miss-counter widths shared with the
// scoring processor and the VGA renderer.
package guitar_note_highway_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } hw_state_e;

  localparam int DEFAULT_LANES = 4;
  localparam int MISS_W        = 16;

endpackage

// File: rtl/guitar_note_highway_game_tick_gen.sv
// rtl/guitar_note_highway_game_tick_gen.sv - scroll-step tick divider
// Purpose: counts 0..TICK_DIV-1 while enabled and pulses game_tick on the
// last count. The count holds while disabled so a pause resumes mid-phase.
// Ports:
//   clock     in  system clock
//   reset     in  async active-low reset
//   enable    in  count enable (busy and not paused)
//   clear     in  synchronous restart of the phase
//   game_tick out one-cycle pulse per scroll step
module game_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic game_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign game_tick = enable & (cnt == LAST);

endmodule

// File: rtl/guitar_note_highway.sv
// rtl/guitar_note_highway.sv - scrolling note highway feeding the scorer and renderer
// Purpose: streams a chart into a DEPTH-row highway, exposes the hit-zone row
// to the scorer, clears accepted hits and counts notes that scroll out unhit.
// Ports:
//   clock, reset          clock and async active-low reset
//   start, pause          song start (edge-detected) and freeze
//   chart_addr/chart_data chart ROM address out, row data in (combinational)
//   hit_valid, hit_lanes  scorer hit acknowledge for row 0
//   game_tick             scroll-step pulse
//   intersections         row 0 of the highway
//   highway               all rows, row r at [r*LANES +: LANES]
//   miss, miss_count      unhit-note pulse and saturating count
//   busy, done            RUN/DRAIN and DONE status
module guitar_note_highway
  import guitar_note_highway_pkg::*;
#(
  parameter int LANES     = DEFAULT_LANES,
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 50000,
  parameter int CHART_LEN = 256,
  parameter int AW        = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  output logic [AW-1:0]          chart_addr,
  input  logic [LANES-1:0]       chart_data,
  input  logic                   hit_valid,
  input  logic [LANES-1:0]       hit_lanes,
  output logic                   game_tick,
  output logic [LANES-1:0]       intersections,
  output logic [LANES*DEPTH-1:0] highway,
  output logic                   miss,
  output logic [MISS_W-1:0]      miss_count,
  output logic                   busy,
  output logic                   done
);

  localparam int PCW = $clog2(LANES + 1);
  localparam int DCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + PCW'(v[i]);
    end
    return c;
  endfunction

  hw_state_e         state;
  logic              start_q;
  logic [LANES-1:0]  rows [DEPTH];
  logic [AW-1:0]     addr_q;
  logic [DCW-1:0]    drain_cnt;
  logic              miss_q;
  logic [MISS_W-1:0] miss_cnt_q;

  logic              busy_w;
  logic              launch;
  logic              tick_en;
  logic [LANES-1:0]  hit_mask;
  logic [LANES-1:0]  row0_eff;
  logic [MISS_W:0]   miss_sum;
  logic [MISS_W-1:0] miss_sat;

  assign busy_w  = (state == ST_RUN) || (state == ST_DRAIN);
  assign launch  = start & ~start_q & ((state == ST_IDLE) || (state == ST_DONE));
  assign tick_en = busy_w & ~pause;

  // Hits are only meaningful while notes are moving; outside RUN/DRAIN they are dropped.
  assign hit_mask = (hit_valid && busy_w) ? hit_lanes : '0;
  assign row0_eff = rows[0] & ~hit_mask;

  // One spare bit catches the carry so the counter sticks at all-ones.
  assign miss_sum = {1'b0, miss_cnt_q} + (MISS_W + 1)'(popcount(row0_eff));
  assign miss_sat = miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];

  game_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock     (clock),
    .reset     (reset),
    .enable    (tick_en),
    .clear     (launch),
    .game_tick (game_tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      addr_q     <= '0;
      drain_cnt  <= '0;
      miss_q     <= 1'b0;
      miss_cnt_q <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        rows[r] <= '0;
      end
    end else begin
      start_q <= start;
      miss_q  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            state      <= ST_RUN;
            addr_q     <= '0;
            drain_cnt  <= '0;
            miss_cnt_q <= '0;
            for (int r = 0; r < DEPTH; r++) begin
              rows[r] <= '0;
            end
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (game_tick) begin
            // Row 0 leaves the highway; judge it after the same-cycle hit clear.
            for (int r = 0; r < DEPTH - 1; r++) begin
              rows[r] <= rows[r+1];
            end
            rows[DEPTH-1] <= (state == ST_RUN) ? chart_data : '0;
            miss_q        <= |row0_eff;
            miss_cnt_q    <= miss_sat;
            if (state == ST_RUN) begin
              addr_q <= addr_q + 1'b1;
              if (addr_q == AW'(CHART_LEN - 1)) begin
                state     <= ST_DRAIN;
                drain_cnt <= '0;
              end
            end else begin
              // DEPTH empty rows push every charted note past the hit zone.
              drain_cnt <= drain_cnt + 1'b1;
              if (drain_cnt == DCW'(DEPTH - 1)) begin
                state <= ST_DONE;
              end
            end
          end else begin
            rows[0] <= row0_eff;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_flat
      assign highway[g*LANES +: LANES] = rows[g];
    end
  endgenerate

  assign chart_addr    = addr_q;
  assign intersections = rows[0];
  assign miss          = miss_q;
  assign miss_count    = miss_cnt_q;
  assign busy          = busy_w;
  assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_guitar_note_highway.sv
// tb/tb_guitar_note_highway.sv - directed self-checking bench for guitar_note_highway
module tb_guitar_note_highway;

  localparam int LANES     = 4;
  localparam int DEPTH     = 4;
  localparam int TICK_DIV  = 4;
  localparam int CHART_LEN = 6;
  localparam int AW        = 3;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic                   pause = 1'b0;
  logic                   hit_valid = 1'b0;
  logic [LANES-1:0]       hit_lanes = '0;
  logic [LANES-1:0]       chart_data;
  logic [AW-1:0]          chart_addr;
  logic                   game_tick;
  logic [LANES-1:0]       intersections;
  logic [LANES*DEPTH-1:0] highway;
  logic                   miss;
  logic [15:0]            miss_count;
  logic                   busy;
  logic                   done;

  logic [3:0] rom [8];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign chart_data = rom[chart_addr];

  guitar_note_highway #(
    .LANES     (LANES),
    .DEPTH     (DEPTH),
    .TICK_DIV  (TICK_DIV),
    .CHART_LEN (CHART_LEN),
    .AW        (AW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .chart_addr    (chart_addr),
    .chart_data    (chart_data),
    .hit_valid     (hit_valid),
    .hit_lanes     (hit_lanes),
    .game_tick     (game_tick),
    .intersections (intersections),
    .highway       (highway),
    .miss          (miss),
    .miss_count    (miss_count),
    .busy          (busy),
    .done          (done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_song();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Waits for the tick cycle (optionally driving a hit in it), then returns on
  // the negedge after the scroll update. period counts cycles since the call.
  task automatic next_tick(input logic hv, input logic [3:0] hl, output int period);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!game_tick && n < 40);
    check_val("tick_seen", game_tick, 1'b1);
    hit_valid = hv;
    hit_lanes = hl;
    @(negedge clock);
    hit_valid = 1'b0;
    hit_lanes = '0;
    period = n + 1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_val("done_seen", done, 1'b1);
  endtask

  initial begin
    int per;
    logic [3:0] exp0;
    logic [3:0] prev0;
    int exp_mc;
    logic gt_seen;

    for (int i = 0; i < 8; i++) rom[i] = 4'h0;

    // Reset state
    #12;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_addr", chart_addr, 0);
    check_val("rst_highway", highway, 0);
    check_val("rst_mc", miss_count, 0);
    check_val("rst_tick", game_tick, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_val("idle_busy", busy, 1'b0);

    // Song A: chart 1,2,4,8,0,F with no hits
    rom[0] = 4'h1; rom[1] = 4'h2; rom[2] = 4'h4;
    rom[3] = 4'h8; rom[4] = 4'h0; rom[5] = 4'hF;
    start_song();
    check_val("a_busy", busy, 1'b1);
    exp_mc = 0;
    prev0  = 4'h0;
    for (int t = 1; t <= 10; t++) begin
      next_tick(1'b0, 4'h0, per);
      check_val("a_period", per, 4);
      exp0 = (t >= 4 && t <= 9) ? rom[t-4] : 4'h0;
      exp_mc = exp_mc + $countones(prev0);
      check_val("a_row0", intersections, exp0);
      check_val("a_miss", miss, (prev0 != 4'h0));
      check_val("a_mc", miss_count, exp_mc);
      check_val("a_addr", chart_addr, (t < 6) ? t : 6);
      prev0 = exp0;
    end
    check_val("a_final_mc", miss_count, 8);
    check_val("a_done", done, 1'b1);
    check_val("a_busy_end", busy, 1'b0);
    check_val("a_highway_end", highway, 0);

    // Song B: same-cycle hit, mid-tick hit, pause
    rom[0] = 4'h3; rom[1] = 4'hF; rom[2] = 4'h5;
    rom[3] = 4'h0; rom[4] = 4'h0; rom[5] = 4'h0;
    start_song();
    check_val("b_mc_clear", miss_count, 0);
    check_val("b_addr_clear", chart_addr, 0);
    for (int t = 1; t <= 4; t++) next_tick(1'b0, 4'h0, per);
    check_val("b_row0_t4", intersections, 4'h3);
    next_tick(1'b1, 4'h3, per);
    check_val("b_hit_nomiss", miss, 1'b0);
    check_val("b_hit_mc", miss_count, 0);
    check_val("b_row0_t5", intersections, 4'hF);
    @(negedge clock);
    hit_valid = 1'b1;
    hit_lanes = 4'h5;
    @(negedge clock);
    hit_valid = 1'b0;
    hit_lanes = 4'h0;
    check_val("b_partial_hit", intersections, 4'hA);
    pause   = 1'b1;
    gt_seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      gt_seen = gt_seen | game_tick;
    end
    check_val("b_pause_notick", gt_seen, 1'b0);
    check_val("b_pause_highway", highway, 16'h005A);
    check_val("b_pause_addr", chart_addr, 5);
    pause = 1'b0;
    next_tick(1'b0, 4'h0, per);
    check_val("b_resume_phase", per, 2);
    check_val("b_miss_t6", miss, 1'b1);
    check_val("b_mc_t6", miss_count, 2);
    check_val("b_row0_t6", intersections, 4'h5);
    wait_done();
    check_val("b_final_mc", miss_count, 4);

    // Song C: saturation, then restart from DONE
    for (int i = 0; i < 6; i++) rom[i] = 4'hF;
    start_song();
    check_val("c_mc_clear", miss_count, 0);
    for (int t = 1; t <= 4; t++) next_tick(1'b0, 4'h0, per);
    check_val("c_row0_t4", intersections, 4'hF);
    dut.miss_cnt_q = 16'hFFFE;
    next_tick(1'b0, 4'h0, per);
    check_val("c_sat", miss_count, 16'hFFFF);
    next_tick(1'b0, 4'h0, per);
    check_val("c_sat_hold", miss_count, 16'hFFFF);
    wait_done();
    start_song();
    check_val("c_restart_mc", miss_count, 0);
    check_val("c_restart_addr", chart_addr, 0);
    check_val("c_restart_busy", busy, 1'b1);

    // Asynchronous reset mid-RUN, away from any clock edge
    next_tick(1'b0, 4'h0, per);
    next_tick(1'b0, 4'h0, per);
    #2;
    reset = 1'b0;
    #1;
    check_val("ar_busy", busy, 1'b0);
    check_val("ar_done", done, 1'b0);
    check_val("ar_addr", chart_addr, 0);
    check_val("ar_highway", highway, 0);
    check_val("ar_row0", intersections, 0);
    check_val("ar_mc", miss_count, 0);
    check_val("ar_miss", miss, 1'b0);
    check_val("ar_tick", game_tick, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_val("ar_stay_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
